// File: rtl/encoder_8b10b_tx.sv
// Transmit 8b/10b encoder, Clause 36 code tables, one-cycle registered latency.
// Optional macro IDLE_COMMA_EN: emit K28.5 commas on idle cycles.
module encoder_8b10b_tx #(
    parameter logic INIT_RD = 1'b0
) (
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic [7:0] TxParallel_8,
    input  logic       TxDataK,
    input  logic       TxValid,
    output logic [9:0] TxParallel_10,
    output logic       TxValid_10,
    output logic       TxRD,
    output logic       code_error
);

    logic       rd;
    logic [4:0] x;
    logic [2:0] y;
    logic       k_req;
    logic       k_legal;
    logic       k_enc;
    logic       illegal;
    logic [5:0] six_m;
    logic [5:0] six;
    logic       flip6;
    logic       rd_mid;
    logic       a7;
    logic [3:0] four_m;
    logic [3:0] four;
    logic       flip4;
    logic       rd_next;
    logic [9:0] sym;

    // 5b/6b codes in abcdei order (a = MSB) for RD-
    function automatic logic [5:0] six_minus(input logic [4:0] v);
        logic [5:0] c;
        unique case (v)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            5'd31: c = 6'b101011;
        endcase
        return c;
    endfunction

    always_comb begin
        x     = TxParallel_8[4:0];
        y     = TxParallel_8[7:5];
        k_req = TxDataK;
`ifdef IDLE_COMMA_EN
        if (!TxValid) begin
            x     = 5'd28;
            y     = 3'd5;
            k_req = 1'b1;
        end
`endif
        k_legal = (x == 5'd28) ||
                  ((y == 3'd7) &&
                   (x == 5'd23 || x == 5'd27 ||
                    x == 5'd29 || x == 5'd30));
        k_enc   = k_req && k_legal;
        illegal = k_req && !k_legal;
    end

    // 5b/6b stage; D.7 is balanced but still has two forms
    always_comb begin
        six_m  = (k_enc && x == 5'd28) ? 6'b001111 : six_minus(x);
        flip6  = ($countones(six_m) != 3) || (x == 5'd7);
        six    = (rd && flip6) ? ~six_m : six_m;
        rd_mid = rd ^ ($countones(six) != 3);
    end

    // 3b/4b stage, selected by the mid-symbol disparity
    always_comb begin
        a7 = (y == 3'd7) &&
             (k_enc ||
              (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        unique case (y)
            3'd0: four_m = 4'b1011;
            3'd1: four_m = k_enc ? 4'b0110 : 4'b1001;
            3'd2: four_m = k_enc ? 4'b1010 : 4'b0101;
            3'd3: four_m = 4'b1100;
            3'd4: four_m = 4'b1101;
            3'd5: four_m = k_enc ? 4'b0101 : 4'b1010;
            3'd6: four_m = k_enc ? 4'b1001 : 4'b0110;
            3'd7: four_m = a7 ? 4'b0111 : 4'b1110;
        endcase
        flip4 = ($countones(four_m) != 2) || (y == 3'd3) ||
                (k_enc && (y == 3'd1 || y == 3'd2 ||
                           y == 3'd5 || y == 3'd6));
        four    = (rd_mid && flip4) ? ~four_m : four_m;
        rd_next = rd_mid ^ ($countones(four) != 2);
        sym     = {four[0], four[1], four[2], four[3],
                   six[0], six[1], six[2], six[3], six[4], six[5]};
    end

    always_ff @(posedge BitCLK_10) begin
        if (Reset) begin
            TxParallel_10 <= 10'h000;
            TxValid_10    <= 1'b0;
            code_error    <= 1'b0;
            rd            <= INIT_RD;
        end else if (TxValid) begin
            TxParallel_10 <= sym;
            TxValid_10    <= 1'b1;
            code_error    <= illegal;
            rd            <= rd_next;
        end else begin
            TxValid_10    <= 1'b0;
`ifdef IDLE_COMMA_EN
            TxParallel_10 <= sym;
            code_error    <= 1'b0;
            rd            <= rd_next;
`endif
        end
    end

    assign TxRD = rd;

endmodule

// File: tb/tb_encoder_8b10b_tx.sv
// Randomized self-checking bench for encoder_8b10b_tx against a table model.
// Follows the DUT build: define IDLE_COMMA_EN for both or neither.
module tb_encoder_8b10b_tx;

    localparam logic INIT = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       kin;
    logic       vin;
    logic [9:0] dout;
    logic       vout;
    logic       rdout;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] m_out;
    logic       m_v;
    logic       m_rd;
    logic       m_err;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] D4M [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] D4P [8] = '{
        4'b0100, 4'b1001, 4'b0101, 4'b0011,
        4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4M [8] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100,
        4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{
        4'b0100, 4'b1001, 4'b0101, 4'b0011,
        4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] KLIST [12] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
        8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    encoder_8b10b_tx #(.INIT_RD(INIT)) dut (
        .BitCLK_10    (clk),
        .Reset        (rst),
        .TxParallel_8 (din),
        .TxDataK      (kin),
        .TxValid      (vin),
        .TxParallel_10(dout),
        .TxValid_10   (vout),
        .TxRD         (rdout),
        .code_error   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void enc(input logic [7:0] d, input logic k,
                                input logic rd, output logic [9:0] s,
                                output logic nrd, output logic ill);
        logic [4:0] x;
        logic [2:0] y;
        logic       legal, kk, rdm, a7;
        logic [5:0] c6;
        logic [3:0] c4;
        x     = d[4:0];
        y     = d[7:5];
        legal = (x == 5'd28) || (y == 3'd7 &&
                (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
        kk    = k && legal;
        ill   = k && !legal;
        if (kk && x == 5'd28) begin
            c6 = rd ? 6'b110000 : 6'b001111;
        end else begin
            c6 = T6[x];
            if (rd && (x == 5'd7 || $countones(c6) != 3)) c6 = ~c6;
        end
        rdm = rd ^ ($countones(c6) != 3);
        a7  = (y == 3'd7) && (kk ||
              (!rdm && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              (rdm && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (a7) c4 = rdm ? 4'b1000 : 4'b0111;
        else if (kk) c4 = rdm ? K4P[y] : K4M[y];
        else c4 = rdm ? D4P[y] : D4M[y];
        for (int i = 0; i < 6; i++) s[i] = c6[5-i];
        for (int i = 0; i < 4; i++) s[6+i] = c4[3-i];
        // symbol disparity alone decides the new running disparity
        nrd = rd ^ ($countones(s) != 5);
    endfunction

    task automatic cycle(input logic r, input logic v,
                         input logic k, input logic [7:0] d);
        logic [9:0] s;
        logic       nrd, ill;
        rst = r;
        vin = v;
        kin = k;
        din = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_out = 10'h000;
            m_v   = 1'b0;
            m_err = 1'b0;
            m_rd  = INIT;
        end else if (v) begin
            enc(d, k, m_rd, s, nrd, ill);
            m_out = s;
            m_v   = 1'b1;
            m_err = ill;
            m_rd  = nrd;
        end else begin
            m_v = 1'b0;
`ifdef IDLE_COMMA_EN
            enc(8'hBC, 1'b1, m_rd, s, nrd, ill);
            m_out = s;
            m_err = 1'b0;
            m_rd  = nrd;
`endif
        end
        check("sym", dout, m_out);
        check("valid", vout, m_v);
        check("rd", rdout, m_rd);
        check("cerr", err, m_err);
        if (vout) check("disp", ($countones(dout) >= 4 &&
                                 $countones(dout) <= 6), 1);
    endtask

    initial begin
        logic [9:0] idle_exp [3];
        logic       idle_rd  [3];
        logic [7:0] b;
        logic       k, v, r;
        rst = 1'b1;
        vin = 1'b0;
        kin = 1'b0;
        din = 8'h00;
        m_out = 10'h000;
        m_v   = 1'b0;
        m_rd  = INIT;
        m_err = 1'b0;

        cycle(1, 0, 0, 8'h00);
        check("rst_sym", dout, 10'h000);
        check("rst_v", vout, 0);
        check("rst_rd", rdout, 0);
        check("rst_err", err, 0);

        cycle(0, 1, 0, 8'h00);
        check("d0_0", dout, 10'h0B9);
        check("d0_0v", vout, 1);
        check("d0_0rd", rdout, 0);

        cycle(0, 1, 1, 8'hBC);
        check("k285a", dout, 10'h17C);
        check("k285a_rd", rdout, 1);
        cycle(0, 1, 1, 8'hBC);
        check("k285b", dout, 10'h283);
        check("k285b_rd", rdout, 0);

        cycle(0, 1, 0, 8'hF1);
        check("d17_7", dout, 10'h3B1);
        check("d17_7rd", rdout, 1);

        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 1, 8'h00);
        check("illk", dout, 10'h0B9);
        check("illk_err", err, 1);
        check("illk_rd", rdout, 0);
        cycle(0, 1, 0, 8'h00);
        check("clr_err", err, 0);

        cycle(0, 1, 1, 8'hBC);
        check("pre_idle", rdout, 1);
`ifdef IDLE_COMMA_EN
        idle_exp = '{10'h283, 10'h17C, 10'h283};
        idle_rd  = '{1'b0, 1'b1, 1'b0};
`else
        idle_exp = '{10'h17C, 10'h17C, 10'h17C};
        idle_rd  = '{1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 8'h55);
            check("idle_sym", dout, idle_exp[i]);
            check("idle_v", vout, 0);
            check("idle_rd", rdout, idle_rd[i]);
        end

        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 1, 8'hBC);
        check("rdp", rdout, 1);
        cycle(1, 1, 0, 8'h00);
        check("mid_rst_sym", dout, 10'h000);
        check("mid_rst_v", vout, 0);
        check("mid_rst_rd", rdout, INIT);
        cycle(0, 1, 0, 8'h00);
        check("post_rst", dout, 10'h0B9);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 3) != 0);
            k = ($urandom_range(0, 3) == 0);
            b = 8'($urandom);
            if (k && $urandom_range(0, 1) == 1)
                b = KLIST[$urandom_range(0, 11)];
            cycle(r, v, k, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
